// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle main controller and the RV32I datapath.
// Handshake: none; every signal is a level sampled on the rising clock edge.
// master = controller (reads IR fields and the zero flag, drives controls),
// slave  = datapath side.
interface multicycle_control_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 zero;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [2:0]           imm_sel;
    logic [1:0]           alu_op;
    logic [1:0]           result_src;
    logic                 illegal;
    logic [3:0]           state_dbg;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  opcode, funct3, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, imm_sel, alu_op, result_src,
               illegal, state_dbg, retired
    );

    modport slave (
        output opcode, funct3, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               alu_src_a, alu_src_b, imm_sel, alu_op, result_src,
               illegal, state_dbg, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore-style main controller for the multicycle RV32I core, with a
// retired-instruction counter and an illegal-opcode pulse.
module multicycle_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_A   = 4'd11,
        S_JALR_B   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_sel;
    logic       retire;

    // State and retired-count registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and per-state control outputs; enables are gated while in reset.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        result_src = 2'd0;
        retire     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target is precomputed into ALUOut here.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                case (bus.opcode)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXEC_R;
                    7'b0010011: state_d = S_EXEC_I;
                    7'b1100011: state_d = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR_A;
                    7'b0110111: state_d = S_LUI;
                    7'b0010111: state_d = S_AUIPC;
                    default:    state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                state_d   = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_op    = 2'd2;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                alu_op    = 2'd2;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // Only Mealy output: beq takes on zero, bne on not-zero.
                alu_src_a = 2'd2;
                alu_op    = 2'd1;
                pc_write  = bus.zero ^ bus.funct3[0];
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR_A: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                state_d   = S_JALR_B;
            end
            S_JALR_B: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd1;
                alu_op    = 2'd3;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Async reset already forces FETCH; keep its write strobes quiet too.
        if (reset) begin
            pc_write  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    // Retired counter advances when a completing state is left; wraps naturally.
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Immediate type follows the IR opcode in every state.
    always_comb begin
        imm_sel = 3'd0;
        case (bus.opcode)
            7'b0100011: imm_sel = 3'd1;
            7'b1100011: imm_sel = 3'd2;
            7'b0110111,
            7'b0010111: imm_sel = 3'd3;
            7'b1101111: imm_sel = 3'd4;
            default:    imm_sel = 3'd0;
        endcase
    end

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.imm_sel    = imm_sel;
    assign bus.alu_op     = alu_op;
    assign bus.result_src = result_src;
    assign bus.illegal    = illegal;
    assign bus.state_dbg  = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle controller: per-cycle output vectors are
// queued from a table of expected state walks and compared as the DUT steps.
// A second instance with a 4-bit counter shares the inputs for the wrap case.
module tb_multicycle_control_unit;

    logic clk;
    logic reset;

    multicycle_control_unit_if #(.CNT_WIDTH(32)) ifc ();
    multicycle_control_unit_if #(.CNT_WIDTH(4))  ifc_n ();

    multicycle_control_unit #(.CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    multicycle_control_unit #(.CNT_WIDTH(4)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_n)
    );

    assign ifc_n.opcode = ifc.opcode;
    assign ifc_n.funct3 = ifc.funct3;
    assign ifc_n.zero   = ifc.zero;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [20:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ret_exp;

    localparam logic [20:0] RST_MASK = 21'h17001;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // Expected vector: {state, pc_w, adr, mem_w, ir_w, reg_w, a, b, imm, op, res, ill}
    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [6:0] op,
                                            input logic [2:0] f3, input logic z);
        logic pw, ad, mw, iw, rw, il;
        logic [1:0] a, b, ao, rs;
        logic [2:0] im;
        pw = 0; ad = 0; mw = 0; iw = 0; rw = 0; il = 0;
        a = 0; b = 0; ao = 0; rs = 0;
        case (st)
            4'd0:  begin iw = 1; pw = 1; b = 2; rs = 2; end
            4'd1:  begin a = 1; b = 1; end
            4'd2:  begin a = 2; b = 1; end
            4'd3:  begin ad = 1; end
            4'd4:  begin rs = 1; rw = 1; end
            4'd5:  begin ad = 1; mw = 1; end
            4'd6:  begin a = 2; ao = 2; end
            4'd7:  begin a = 2; b = 1; ao = 2; end
            4'd8:  begin rw = 1; end
            4'd9:  begin a = 2; ao = 1; pw = z ^ f3[0]; end
            4'd10: begin a = 1; b = 2; pw = 1; end
            4'd11: begin a = 2; b = 1; end
            4'd12: begin a = 1; b = 2; pw = 1; end
            4'd13: begin a = 3; b = 1; ao = 3; end
            4'd14: begin a = 1; b = 1; end
            default: begin il = 1; end
        endcase
        case (op)
            OP_SW:            im = 3'd1;
            OP_BR:            im = 3'd2;
            OP_LUI, OP_AUIPC: im = 3'd3;
            OP_JAL:           im = 3'd4;
            default:          im = 3'd0;
        endcase
        return {st, pw, ad, mw, iw, rw, a, b, im, ao, rs, il};
    endfunction

    function automatic logic [20:0] observe();
        return {ifc.state_dbg, ifc.pc_write, ifc.adr_src, ifc.mem_write, ifc.ir_write,
                ifc.reg_write, ifc.alu_src_a, ifc.alu_src_b, ifc.imm_sel, ifc.alu_op,
                ifc.result_src, ifc.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- driver ----------------
    // Entered just after a rising edge with the DUT in FETCH; seq holds the
    // expected state walk, one nibble per cycle, lowest nibble first.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input int n, input logic [23:0] seq,
                             input logic retires);
        ifc.opcode = op;
        ifc.funct3 = f3;
        ifc.zero   = z;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(seq[4*i +: 4], op, f3, z));
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({tag, "_retired"}, ifc.retired, ret_exp);
                check({tag, "_retired4"}, {28'd0, ifc_n.retired}, {28'd0, ret_exp[3:0]});
            end
            check(tag, {11'd0, observe()}, {11'd0, exp_q.pop_front()});
            @(posedge clk);
            #1;
        end
        if (retires) ret_exp = ret_exp + 32'd1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        ifc.opcode = 7'd0;
        ifc.funct3 = 3'd0;
        ifc.zero   = 1'b0;
        ret_exp    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vec", {11'd0, observe()}, {11'd0, exp_vec(4'd0, 7'd0, 3'd0, 1'b0) & ~RST_MASK});
        check("reset_retired", ifc.retired, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr("lw",      OP_LW,    3'b010, 1'b0, 5, 24'h043210, 1'b1);
        run_instr("sw",      OP_SW,    3'b010, 1'b0, 4, 24'h005210, 1'b1);
        run_instr("beq_t",   OP_BR,    3'b000, 1'b1, 3, 24'h000910, 1'b1);
        run_instr("beq_nt",  OP_BR,    3'b000, 1'b0, 3, 24'h000910, 1'b1);
        run_instr("bne_t",   OP_BR,    3'b001, 1'b0, 3, 24'h000910, 1'b1);
        run_instr("bne_nt",  OP_BR,    3'b001, 1'b1, 3, 24'h000910, 1'b1);
        run_instr("jalr",    OP_JALR,  3'b000, 1'b0, 5, 24'h08CB10, 1'b1);
        run_instr("jal",     OP_JAL,   3'b000, 1'b0, 4, 24'h008A10, 1'b1);
        run_instr("itype",   OP_I,     3'b100, 1'b0, 4, 24'h008710, 1'b1);
        run_instr("lui",     OP_LUI,   3'b000, 1'b0, 4, 24'h008D10, 1'b1);
        run_instr("auipc",   OP_AUIPC, 3'b000, 1'b0, 4, 24'h008E10, 1'b1);
        run_instr("illegal", OP_BAD,   3'b000, 1'b0, 3, 24'h000F10, 1'b0);
        run_instr("blt_ill", OP_BR,    3'b100, 1'b1, 3, 24'h000F10, 1'b0);
        run_instr("rtype",   OP_R,     3'b000, 1'b0, 4, 24'h008610, 1'b1);

        // Reset mid-MEMREAD: walk LW to MEMREAD, then pulse reset.
        run_instr("lw_part", OP_LW, 3'b010, 1'b0, 3, 24'h000210, 1'b0);
        @(negedge clk);
        check("memread", {11'd0, observe()}, {11'd0, exp_vec(4'd3, OP_LW, 3'b010, 1'b0)});
        #1 reset = 1'b1;
        #1;
        check("rst_mid_vec", {11'd0, observe()}, {11'd0, exp_vec(4'd0, OP_LW, 3'b010, 1'b0) & ~RST_MASK});
        check("rst_mid_retired", ifc.retired, 32'd0);
        @(negedge clk);
        check("rst_hold_vec", {11'd0, observe()}, {11'd0, exp_vec(4'd0, OP_LW, 3'b010, 1'b0) & ~RST_MASK});
        @(posedge clk);
        #1 reset = 1'b0;
        ret_exp = 32'd0;
        #1;
        check("post_rst_fetch", {11'd0, observe()}, {11'd0, exp_vec(4'd0, OP_LW, 3'b010, 1'b0)});

        // Sixteen R-type instructions wrap the 4-bit counter back to zero.
        for (int k = 0; k < 16; k++) begin
            run_instr("wrap_r", OP_R, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      4, 24'h008610, 1'b1);
        end
        @(negedge clk);
        check("wrap_retired4", {28'd0, ifc_n.retired}, 32'd0);
        check("wrap_retired", ifc.retired, 32'd16);
        check("wrap_q_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style main controller FSM for the multicycle RV32I core.
- Sits directly upstream of the datapath. Decodes the instruction register fields each cycle.
- Drives the datapath controls: PC write, address mux, memory write, IR/OldPC write, register-file write, SrcA/SrcB muxes, immediate select, ALU operation class and result mux.
- Also keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  7  instruction register bits [6:0]
- funct3  input  3  instruction register bits [14:12]
- zero  input  1  ALU zero flag, combinational from the current cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address mux select: 0=PC, 1=ALUOut
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register and OldPC register enable
- reg_write  output  1  register file write enable
- alu_src_a  output  2  SrcA select: 0=PC, 1=OldPC, 2=rs1 register, 3=zero
- alu_src_b  output  2  SrcB select: 0=rs2 register, 1=imm, 2=constant 4
- imm_sel  output  3  immediate type: 0=I, 1=S, 2=B, 3=U, 4=J
- alu_op  output  2  ALU operation class: 0=add, 1=subtract/compare, 2=funct-decoded, 3=pass B
- result_src  output  2  result mux select: 0=ALUOut, 1=Data register, 2=ALU result
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct3
- state_dbg  output  4  current state encoding
- retired  output  CNT_WIDTH  count of completed instructions

Behaviour:
- Single clock domain, clk. reset is asynchronous and active-high.
- Reset (asynchronous):
  - state goes to FETCH; retired goes to 0.
  - While reset is high, pc_write, mem_write, ir_write, reg_write and illegal are all forced to 0.
  - Mux selects follow the FETCH state values.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, JALR_A=11, JALR_B=12
  - LUI=13, AUIPC=14, ILLEGAL=15
- Outputs listed per state. Any output not listed is 0.
  - FETCH: adr_src=0, ir_write=1, alu_src_a=0, alu_src_b=2, alu_op=0, result_src=2, pc_write=1.
  - DECODE: alu_src_a=1, alu_src_b=1, alu_op=0. This precomputes the branch/jump target into ALUOut.
  - MEMADR: alu_src_a=2, alu_src_b=1, alu_op=0.
  - MEMREAD: adr_src=1, result_src=0.
  - MEMWB: result_src=1, reg_write=1.
  - MEMWRITE: adr_src=1, result_src=0, mem_write=1.
  - EXEC_R: alu_src_a=2, alu_src_b=0, alu_op=2.
  - EXEC_I: alu_src_a=2, alu_src_b=1, alu_op=2.
  - ALUWB: result_src=0, reg_write=1.
  - BRANCH: alu_src_a=2, alu_src_b=0, alu_op=1, result_src=0.
    - pc_write = zero XOR funct3[0] (beq/bne). This is the only Mealy output.
  - JAL: alu_src_a=1, alu_src_b=2, alu_op=0, result_src=0, pc_write=1.
  - JALR_A: alu_src_a=2, alu_src_b=1, alu_op=0.
  - JALR_B: alu_src_a=1, alu_src_b=2, alu_op=0, result_src=0, pc_write=1.
  - LUI: alu_src_a=3, alu_src_b=1, alu_op=3.
  - AUIPC: alu_src_a=1, alu_src_b=1, alu_op=0.
  - ILLEGAL: illegal=1.
- imm_sel is combinational from opcode in every state, so it stays stable after IR load:
  - S for 0100011, B for 1100011, U for 0110111 and 0010111, J for 1101111, I otherwise.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE dispatches on opcode:
    - 0000011 and 0100011 go to MEMADR.
    - 0110011 goes to EXEC_R; 0010011 goes to EXEC_I.
    - 1100011 with funct3 of 000 or 001 goes to BRANCH.
    - 1101111 goes to JAL; 1100111 goes to JALR_A.
    - 0110111 goes to LUI; 0010111 goes to AUIPC.
    - Anything else, including a branch with another funct3, goes to ILLEGAL.
  - MEMADR goes to MEMREAD if opcode[5]=0, otherwise to MEMWRITE.
  - MEMREAD goes to MEMWB.
  - EXEC_R, EXEC_I, JAL, LUI and AUIPC go to ALUWB.
  - JALR_A goes to JALR_B, then to ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH and ILLEGAL go to FETCH.
- Latency in cycles:
  - R/I-type, LUI, AUIPC, SW, JAL: 4
  - LW, JALR: 5
  - Branch: 3
  - Illegal: 3
- retired increments by 1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Not incremented on leaving ILLEGAL.
  - Wraps modulo 2^CNT_WIDTH.
- Reset asserted mid-instruction aborts immediately. No write enable may be high in the cycle reset is asserted.

Test Plan:
- Reset pulse mid-MEMREAD → state_dbg=0 immediately, retired=0, all write enables 0 while reset is high; FETCH outputs appear after reset deasserts.
- opcode=0000011 (LW) → state_dbg sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=1; retired +1.
- opcode=0100011 (SW) → sequence 0,1,2,5,0; mem_write=1 only in state 5 with adr_src=1; imm_sel=1 throughout.
- opcode=1100011, funct3=000: with zero=1 → pc_write=1 in state 9; with zero=0 → pc_write=0. Repeat with funct3=001 → pc_write behaviour inverted. Sequence is 3 cycles.
- opcode=1100111 (JALR) → sequence 0,1,11,12,8,0; in state 12 pc_write=1, alu_src_a=1, alu_src_b=2; reg_write=1 in state 8.
- opcode=1111111 → sequence 0,1,15,0; illegal pulses for exactly 1 cycle; retired unchanged.
- Counter wrap: run with CNT_WIDTH=4, 16 R-type instructions → retired returns to 0.
